// File: rtl/axis_pkg.sv
// axis_pkg: shared FSM encoding, widths and saturating-increment helper for the AXI-Stream receiver
package axis_pkg;
  localparam int AXIS_CNT_W = 16;
  localparam int AXIS_ID_W = 8;
  typedef enum logic [1:0] {SOP = 2'd0, PASS = 2'd1, DISCARD = 2'd2} axis_state_e;
  function automatic logic [AXIS_CNT_W-1:0] sat_inc(input logic [AXIS_CNT_W-1:0] c, input logic inc);
    return (inc && c != '1) ? c + AXIS_CNT_W'(1) : c;
  endfunction
endpackage

// File: rtl/axis_rx_fifo.sv
// axis_rx_fifo: sync FWFT FIFO; push/wdata in, pop/rdata out (rdata 0 when empty), full/empty/level status
module axis_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge i_clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/axi_stream_read_extended.sv
// axi_stream_read_extended: AXI-S sink (tvalid/tready/tdata/tkeep/tdest/tid/tlast) with TDEST filter into FWFT FIFO read via o_data_valid/i_read; level and saturating pkt/drop counts
module axi_stream_read_extended
  import axis_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [31:0]                   i_core_TID,
  input  logic                          i_filter_en,
  input  logic                          i_tvalid,
  output logic                          o_tready,
  input  logic [BUS_WIDTH-1:0]          i_tdata,
  input  logic [BUS_WIDTH/8-1:0]        i_tkeep,
  input  logic [AXIS_ID_W-1:0]          i_tdest,
  input  logic [AXIS_ID_W-1:0]          i_tid,
  input  logic                          i_tlast,
  output logic                          o_data_valid,
  input  logic                          i_read,
  output logic [BUS_WIDTH-1:0]          o_data,
  output logic [BUS_WIDTH/8-1:0]        o_tkeep,
  output logic [AXIS_ID_W-1:0]          o_tdest,
  output logic [AXIS_ID_W-1:0]          o_tid,
  output logic                          o_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic [AXIS_CNT_W-1:0]         o_pkt_count,
  output logic [AXIS_CNT_W-1:0]         o_drop_count
);
  localparam int WW = BUS_WIDTH + BUS_WIDTH / 8 + 2 * AXIS_ID_W + 1;
  axis_state_e state, state_n;
  logic full, empty, drop, xfer, push;
  logic [WW-1:0] rdata;
  logic unused_tid;
  assign unused_tid = ^i_core_TID[31:AXIS_ID_W];
  assign drop = i_filter_en && (i_tdest != i_core_TID[AXIS_ID_W-1:0]);
  // Dropped packets are drained even when the FIFO is full so a filtered stream never stalls.
  assign o_tready = !i_reset && (state == DISCARD || (state == SOP && drop) || !full);
  assign xfer = i_tvalid && o_tready;
  assign push = xfer && (state == PASS || (state == SOP && !drop));
  always_comb begin
    state_n = state;
    if (xfer) state_n = i_tlast ? SOP : (state == SOP ? (drop ? DISCARD : PASS) : state);
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= SOP;
      o_pkt_count <= '0;
      o_drop_count <= '0;
    end else begin
      state <= state_n;
      o_pkt_count <= sat_inc(o_pkt_count, push && i_tlast);
      o_drop_count <= sat_inc(o_drop_count, xfer && !push && i_tlast);
    end
  axis_rx_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (push),
    .wdata   ({i_tlast, i_tid, i_tdest, i_tkeep, i_tdata}),
    .pop     (i_read),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .level   (o_level)
  );
  assign {o_tlast, o_tid, o_tdest, o_tkeep, o_data} = rdata;
  assign o_data_valid = !empty;
endmodule

// File: doc/axi_stream_read_extended.md
Name: axi_stream_read_extended

Overview:
- AXI-Stream receiver. Sink for the TKEEP/TLAST/TDEST/TID stream produced by the core's stream writer.
- Accepts beats into a small first-word-fall-through FIFO and presents them to core logic through a simple valid/read interface.
- Optional packet-level filter on TDEST: packets not addressed to this core are drained and discarded.
- Keeps saturating counts of stored packets and dropped packets for status readback.

Parameters:
- BUS_WIDTH, 16: data bus width in bits; multiple of 8.
- FIFO_DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_core_TID  in  32  core ID; bits [7:0] are compared against TDEST.
- i_filter_en  in  1  1 = discard packets whose TDEST != i_core_TID[7:0].
- i_tvalid  in  1  AXI-S TVALID.
- o_tready  out  1  AXI-S TREADY.
- i_tdata  in  BUS_WIDTH  AXI-S TDATA.
- i_tkeep  in  BUS_WIDTH/8  AXI-S TKEEP.
- i_tdest  in  8  AXI-S TDEST.
- i_tid  in  8  AXI-S TID.
- i_tlast  in  1  AXI-S TLAST.
- o_data_valid  out  1  FIFO head is valid.
- i_read  in  1  pops the head when o_data_valid=1.
- o_data  out  BUS_WIDTH  head TDATA.
- o_tkeep  out  BUS_WIDTH/8  head TKEEP.
- o_tdest  out  8  head TDEST.
- o_tid  out  8  head TID.
- o_tlast  out  1  head TLAST.
- o_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_pkt_count  out  16  stored packets (beats stored with TLAST=1); saturates at 0xFFFF.
- o_drop_count  out  16  discarded packets; saturates at 0xFFFF.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - FIFO emptied; FSM set to SOP.
  - o_data_valid=0, o_level=0, o_pkt_count=0, o_drop_count=0.
  - Head data outputs (o_data, o_tkeep, o_tdest, o_tid, o_tlast) read 0.
  - o_tready=0 during the reset cycle.
  - Reset mid-packet abandons the packet; the next beat is treated as start of packet.
- Handshake: a beat transfers when i_tvalid=1 and o_tready=1 at a clock edge. o_tready never depends on i_tvalid combinationally.
- FSM states:
  - SOP, start of packet:
    - Drop condition: i_filter_en=1 and i_tdest != i_core_TID[7:0], evaluated on the current beat.
    - If the drop condition is met: o_tready=1 unconditionally. On a transfer: if TLAST=1, o_drop_count+1 and stay in SOP; otherwise go to DISCARD.
    - Otherwise: o_tready = !full. On a transfer: push the beat; if TLAST=1, o_pkt_count+1 and stay in SOP; otherwise go to PASS.
  - PASS: o_tready = !full. Every transferred beat is pushed with no further filtering. A TLAST beat gives o_pkt_count+1 and returns to SOP.
  - DISCARD: o_tready=1. Beats are dropped. A TLAST beat gives o_drop_count+1 and returns to SOP.
- Filter timing: i_filter_en and i_core_TID are sampled only at SOP. Changes in mid-packet do not affect the packet in flight.
- FIFO, first-word fall-through:
  - A beat pushed at edge N appears on o_data* with o_data_valid=1 after edge N, if the FIFO was empty.
  - Pop occurs when i_read=1 and o_data_valid=1 at an edge. i_read while empty is ignored.
  - Full means o_level == FIFO_DEPTH. When full, o_tready=0 even if a pop occurs in the same cycle; no combinational path from i_read to o_tready.
  - Simultaneous push and pop when not full: o_level is unchanged.
  - Pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Payload: TKEEP, TDEST and TID are stored unchanged. An all-zero TKEEP beat is stored as is.
- Counters: saturate at 0xFFFF and do not wrap.

Decomposition:
- Shared package axis_pkg holds:
  - FSM state encoding: SOP=2'd0, PASS=2'd1, DISCARD=2'd2.
  - Counter width constant AXIS_CNT_W=16.
  - AXIS_ID_W=8.
- One sub-module, axis_rx_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty/level.
  - Stored word = {tlast, tid, tdest, tkeep, tdata}.
  - Top level holds the FSM, filter and counters.

Test Plan:
- Reset then single beat:
  - Stimulus: i_filter_en=0; beat tdata=0xA5A5, tkeep=2'b11, tdest=3, tid=7, tlast=1.
  - Response: one cycle later o_data_valid=1, o_data=0xA5A5, o_tdest=3, o_tid=7, o_tlast=1, o_level=1, o_pkt_count=1.
- Backpressure:
  - Stimulus: stream 6 beats with i_read=0.
  - Response: o_tready=0 after 4 beats, o_level=4. Then i_read=1 for one cycle: o_tready=1 the following cycle, beat 5 accepted, and data order is preserved across wrap.
- Filter drop:
  - Stimulus: i_core_TID=5, i_filter_en=1; 3-beat packet with tdest=2 (last beat only has tlast=1), with the FIFO full.
  - Response: o_tready=1 for all 3 beats, o_level unchanged, o_drop_count=1, o_pkt_count unchanged.
- Filter pass mid-packet:
  - Stimulus: first beat tdest=5 with i_core_TID=5, i_filter_en=1; later beats tdest=9.
  - Response: all beats stored, o_pkt_count+1.
- Reset mid-packet:
  - Stimulus: 2 beats of a 4-beat packet, then a 1-cycle i_reset.
  - Response: o_level=0, o_data_valid=0, counters=0. The next beat with tdest mismatch (filter on) is dropped as a new SOP.
- Read while empty and simultaneous push/pop:
  - Stimulus: i_read=1 while empty.
  - Response: no change.
  - Stimulus: push and pop in the same cycle at o_level=2.
  - Response: o_level stays 2.
